// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames, LSB first, 16x oversampling on a shared tick.
// Delivers bytes through a valid/read handshake and keeps sticky framing and
// overrun flags until they are explicitly cleared.
module uart_receiver #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sck_rising_edge,
   input  logic       sin,
   output logic       busy,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   input  logic       rx_data_read,
   output logic       frame_error,
   output logic       overrun_error,
   input  logic       error_clear
);

   localparam int unsigned EDGE_W = 4;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_ACTIVE = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                w_sin_s;
   logic [EDGE_W-1:0]   r_edges;
   logic [EDGE_W-1:0]   w_edges_nxt;
   logic [BIT_W-1:0]    r_bits;
   logic [BIT_W-1:0]    w_bits_nxt;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic [DATA_W-1:0]   r_rx_data;
   logic [DATA_W-1:0]   w_rx_data_nxt;
   logic                r_valid;
   logic                w_valid_nxt;
   logic                r_frame_err;
   logic                w_frame_err_nxt;
   logic                r_overrun_err;
   logic                w_overrun_err_nxt;
   logic                w_deliver;
   logic                w_frame_set;
   logic                w_overrun_set;

   // Metastability chain on the asynchronous line; idles high out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sin};
      end
   end

   assign w_sin_s = r_sync[SYNC_STAGES-1];

   // State, counters, shift register and handshake/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_edges       <= '0;
         r_bits        <= '0;
         r_shift       <= '0;
         r_rx_data     <= '0;
         r_valid       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_edges       <= w_edges_nxt;
         r_bits        <= w_bits_nxt;
         r_shift       <= w_shift_nxt;
         r_rx_data     <= w_rx_data_nxt;
         r_valid       <= w_valid_nxt;
         r_frame_err   <= w_frame_err_nxt;
         r_overrun_err <= w_overrun_err_nxt;
      end
   end

   // Frame sequencing: start validation at mid-bit, then one sample per 16 ticks.
   always_comb begin
      w_state_nxt = r_state;
      w_edges_nxt = r_edges;
      w_bits_nxt  = r_bits;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_frame_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_sin_s) begin
               w_state_nxt = S_START;
               w_edges_nxt = '0;
            end
         end
         S_START: begin
            if (sck_rising_edge) begin
               if (r_edges == EDGE_W'(7)) begin
                  w_edges_nxt = '0;
                  w_state_nxt = w_sin_s ? S_IDLE : S_ACTIVE;
               end else begin
                  w_edges_nxt = EDGE_W'(r_edges + EDGE_W'(1));
               end
            end
         end
         S_ACTIVE: begin
            if (sck_rising_edge) begin
               if (r_edges == EDGE_W'(15)) begin
                  w_edges_nxt = '0;
                  w_shift_nxt = {w_sin_s, r_shift[DATA_W-1:1]};
                  if (r_bits == BIT_W'(7)) begin
                     w_bits_nxt  = '0;
                     w_state_nxt = S_STOP;
                  end else begin
                     w_bits_nxt = BIT_W'(r_bits + BIT_W'(1));
                  end
               end else begin
                  w_edges_nxt = EDGE_W'(r_edges + EDGE_W'(1));
               end
            end
         end
         S_STOP: begin
            if (sck_rising_edge) begin
               if (r_edges == EDGE_W'(15)) begin
                  w_edges_nxt = '0;
                  if (w_sin_s) begin
                     w_deliver   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_frame_set = 1'b1;
                     w_state_nxt = S_BREAK;
                  end
               end else begin
                  w_edges_nxt = EDGE_W'(r_edges + EDGE_W'(1));
               end
            end
         end
         S_BREAK: begin
            if (w_sin_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Consumer handshake and sticky flags; a set beats a coincident clear.
   always_comb begin
      w_rx_data_nxt     = r_rx_data;
      w_valid_nxt       = r_valid;
      w_overrun_set     = 1'b0;
      if (w_deliver) begin
         w_rx_data_nxt = r_shift;
         w_valid_nxt   = 1'b1;
         w_overrun_set = r_valid && !rx_data_read;
      end else if (rx_data_read) begin
         w_valid_nxt = 1'b0;
      end
      w_frame_err_nxt   = w_frame_set   ? 1'b1 : (error_clear ? 1'b0 : r_frame_err);
      w_overrun_err_nxt = w_overrun_set ? 1'b1 : (error_clear ? 1'b0 : r_overrun_err);
   end

   assign busy          = (r_state != S_IDLE);
   assign rx_data       = r_rx_data;
   assign rx_data_valid = r_valid;
   assign frame_error   = r_frame_err;
   assign overrun_error = r_overrun_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a behavioural serial transmitter drives frames on a
// shared 16x tick, and a byte-level model predicts the register-side view.
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck_rising_edge = 1'b0;
   logic       sin = 1'b1;
   logic       rx_data_read = 1'b0;
   logic       error_clear = 1'b0;
   logic       busy;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       frame_error;
   logic       overrun_error;

   int n_cmp = 0;
   int n_bad = 0;

   // Byte-level reference model of what the register block should see
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ferr;
   logic       m_oerr;

   uart_receiver #(.SYNC_STAGES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sck_rising_edge (sck_rising_edge),
      .sin             (sin),
      .busy            (busy),
      .rx_data         (rx_data),
      .rx_data_valid   (rx_data_valid),
      .rx_data_read    (rx_data_read),
      .frame_error     (frame_error),
      .overrun_error   (overrun_error),
      .error_clear     (error_clear)
   );

   initial forever #5 clk = ~clk;

   // 16x baud tick: one clk high out of every four
   initial forever begin
      repeat (3) @(negedge clk);
      sck_rising_edge = 1'b1;
      @(negedge clk);
      sck_rising_edge = 1'b0;
   end

   task automatic wait_tick();
      do @(posedge clk); while (sck_rising_edge !== 1'b1);
      #1;
   endtask

   task automatic model_reset();
      m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
   endtask

   // What a completed frame does to the consumer-visible state
   task automatic model_frame(input logic [7:0] d, input logic stop, input bit rd_same);
      if (stop) begin
         if (m_valid && !rd_same) m_oerr = 1'b1;
         m_data  = d;
         m_valid = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   // Serial transmitter: start, 8 data LSB first, stop; each bit lasts 16 ticks.
   // Optionally pulses rx_data_read for the single clk of the stop-bit mid-sample.
   task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd_at_stop,
                             input int nticks);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      wait_tick();
      for (int t = 0; t < nticks; t++) begin
         sin = fr[4'(t / 16)];
         if (rd_at_stop && t == 151) begin
            repeat (3) @(posedge clk);
            #1 rx_data_read = 1'b1;
         end
         wait_tick();
         rx_data_read = 1'b0;
      end
   endtask

   task automatic pulse_read();
      rx_data_read = 1'b1;
      @(posedge clk);
      #1 rx_data_read = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      error_clear = 1'b1;
      @(posedge clk);
      #1 error_clear = 1'b0;
      m_ferr = 1'b0;
      m_oerr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sin   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
      n_cmp++; if (rx_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_data_valid); end
      n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
      n_cmp++; if (overrun_error !== 1'b0) begin n_bad++; $display("FAIL reset_oerr: got %b want 0", overrun_error); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) wait_tick();
   endtask

   task automatic test_loopback();
      send_frame(8'hA5, 1'b1, 1'b0, 160);
      model_frame(8'hA5, 1'b1, 1'b0);
      n_cmp++; if (rx_data !== m_data) begin n_bad++; $display("FAIL loop_data: got %h want %h", rx_data, m_data); end
      n_cmp++; if (rx_data_valid !== 1'b1) begin n_bad++; $display("FAIL loop_valid: got %b want 1", rx_data_valid); end
      n_cmp++; if (frame_error !== 1'b0 || overrun_error !== 1'b0) begin
         n_bad++; $display("FAIL loop_err: got f=%b o=%b want 0 0", frame_error, overrun_error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL loop_busy: got %b want 0", busy); end
      pulse_read();
      n_cmp++; if (rx_data_valid !== 1'b0) begin n_bad++; $display("FAIL loop_read: got valid %b want 0", rx_data_valid); end
   endtask

   task automatic test_glitch();
      wait_tick();
      sin = 1'b0;
      repeat (2) wait_tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
      repeat (2) wait_tick();
      sin = 1'b1;
      repeat (12) wait_tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
      n_cmp++; if (rx_data_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %b want 0", rx_data_valid); end
      n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL glitch_ferr: got %b want 0", frame_error); end
   endtask

   task automatic test_frame_error();
      send_frame(8'h3C, 1'b0, 1'b0, 160);
      model_frame(8'h3C, 1'b0, 1'b0);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_held: got %b want 1", busy); end
      n_cmp++; if (rx_data !== m_data) begin n_bad++; $display("FAIL ferr_data: got %h want %h", rx_data, m_data); end
      n_cmp++; if (rx_data_valid !== m_valid) begin n_bad++; $display("FAIL ferr_valid: got %b want %b", rx_data_valid, m_valid); end
      n_cmp++; if (frame_error !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", frame_error); end
      sin = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_rel: got %b want 0", busy); end
      n_cmp++; if (frame_error !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b want 1", frame_error); end
      pulse_clear();
      n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL ferr_clear: got %b want 0", frame_error); end
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b1, 1'b0, 160);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 160);
      model_frame(8'h22, 1'b1, 1'b0);
      n_cmp++; if (rx_data !== m_data) begin n_bad++; $display("FAIL ovr_data: got %h want %h", rx_data, m_data); end
      n_cmp++; if (rx_data_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", rx_data_valid); end
      n_cmp++; if (overrun_error !== m_oerr) begin n_bad++; $display("FAIL ovr_flag: got %b want %b", overrun_error, m_oerr); end
      pulse_clear();
      n_cmp++; if (overrun_error !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun_error); end
      n_cmp++; if (rx_data_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_kept: got %b want 1", rx_data_valid); end
   endtask

   task automatic test_back_to_back_read();
      pulse_read();
      send_frame(8'h11, 1'b1, 1'b0, 160);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1, 160);
      model_frame(8'h22, 1'b1, 1'b1);
      n_cmp++; if (rx_data_valid !== 1'b1) begin n_bad++; $display("FAIL same_valid: got %b want 1", rx_data_valid); end
      n_cmp++; if (rx_data !== 8'h22) begin n_bad++; $display("FAIL same_data: got %h want 22", rx_data); end
      n_cmp++; if (overrun_error !== 1'b0) begin n_bad++; $display("FAIL same_oerr: got %b want 0", overrun_error); end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'hFF, 1'b1, 1'b0, 64);
      rst_n = 1'b0;
      sin   = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (rx_data !== 8'h00 || rx_data_valid !== 1'b0) begin
         n_bad++; $display("FAIL mid_out: got %h/%b want 00/0", rx_data, rx_data_valid); end
      n_cmp++; if (frame_error !== 1'b0 || overrun_error !== 1'b0) begin
         n_bad++; $display("FAIL mid_err: got f=%b o=%b want 0 0", frame_error, overrun_error); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) wait_tick();
      send_frame(8'h5A, 1'b1, 1'b0, 160);
      model_frame(8'h5A, 1'b1, 1'b0);
      n_cmp++; if (rx_data !== 8'h5A || rx_data_valid !== 1'b1) begin
         n_bad++; $display("FAIL mid_next: got %h/%b want 5a/1", rx_data, rx_data_valid); end
      n_cmp++; if (overrun_error !== 1'b0) begin n_bad++; $display("FAIL mid_next_oerr: got %b want 0", overrun_error); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       stop;
      bit         rd;
      for (int i = 0; i < 14; i++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         rd   = stop && ($urandom_range(0, 3) == 0);
         send_frame(d, stop, rd, 160);
         model_frame(d, stop, rd);
         if (!stop) begin
            sin = 1'b1;
            repeat (4) @(posedge clk);
            #1;
         end
         n_cmp++; if (rx_data !== m_data) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rx_data, m_data); end
         n_cmp++; if (rx_data_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, rx_data_valid, m_valid); end
         n_cmp++; if (frame_error !== m_ferr) begin n_bad++; $display("FAIL rnd_ferr[%0d]: got %b want %b", i, frame_error, m_ferr); end
         n_cmp++; if (overrun_error !== m_oerr) begin n_bad++; $display("FAIL rnd_oerr[%0d]: got %b want %b", i, overrun_error, m_oerr); end
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want 0", i, busy); end
         if ($urandom_range(0, 1) == 1) pulse_read();
         if ($urandom_range(0, 2) == 0) pulse_clear();
         repeat ($urandom_range(0, 3)) wait_tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_loopback();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_back_to_back_read();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
